// File: rtl/sprite_pkg.sv
// sprite_pkg: shared screen/sprite defaults and axis FSM encodings
package sprite_pkg;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    localparam int SPRITE_W_DEF = 32;
    localparam int SPRITE_H_DEF = 32;
    localparam int POS_W_DEF    = 10;
    localparam int INIT_X_DEF   = 304;
    localparam int INIT_Y_DEF   = 448;
    localparam int SPEED_W      = 3;

    typedef logic [1:0] axis_state_t;

    localparam axis_state_t ST_IDLE   = 2'd0;
    localparam axis_state_t ST_ACCEL  = 2'd1;
    localparam axis_state_t ST_CRUISE = 2'd2;

    localparam logic DIR_NEG = 1'b0;
    localparam logic DIR_POS = 1'b1;

endpackage

// File: rtl/sprite_axis_motion.sv
// sprite_axis_motion: one axis of IDLE/ACCEL/CRUISE speed ramp with clamped position
module sprite_axis_motion
    import sprite_pkg::*;
#(
    parameter int POS_W       = POS_W_DEF,
    parameter int LIMIT       = 608,
    parameter int INIT        = 0,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_TICKS = 8
) (
    input  logic               clk25,
    input  logic               rst_n,
    input  logic               step_en,
    input  logic               req_neg,
    input  logic               req_pos,
    output logic [POS_W-1:0]   pos,
    output logic [SPEED_W-1:0] speed
);

    localparam int                 CW        = ACCEL_TICKS > 1 ? $clog2(ACCEL_TICKS) : 1;
    localparam logic [CW-1:0]      HELD_LAST = CW'(ACCEL_TICKS - 1);
    localparam logic [POS_W:0]     LIM       = (POS_W+1)'(LIMIT);
    localparam logic [SPEED_W-1:0] SPD_MAX   = SPEED_W'(MAX_SPEED);

    axis_state_t        state, state_nx;
    logic               dir, dir_nx;
    logic [CW-1:0]      held, held_nx;
    logic [SPEED_W-1:0] spd, speed_nx;
    logic [POS_W:0]     cur, step, inc, target;
    logic               req, hit;

    // Resolve the request, ramp speed, move with clamping and stop on reaching a limit
    always_comb begin
        req      = req_neg ^ req_pos;
        state_nx = state;
        dir_nx   = dir;
        held_nx  = held;
        spd      = speed;
        if (!req) begin
            state_nx = ST_IDLE;
            held_nx  = '0;
            spd      = '0;
        end else if (state == ST_IDLE || (req_pos ? DIR_POS : DIR_NEG) != dir) begin
            state_nx = ST_ACCEL;
            dir_nx   = req_pos ? DIR_POS : DIR_NEG;
            held_nx  = '0;
            spd      = SPEED_W'(1);
        end else if (state == ST_ACCEL) begin
            held_nx  = held == HELD_LAST ? '0 : held + 1'b1;
            spd      = (held == HELD_LAST && speed < SPD_MAX) ? speed + 1'b1 : speed;
            state_nx = spd == SPD_MAX ? ST_CRUISE : ST_ACCEL;
        end
        cur      = {1'b0, pos};
        step     = (POS_W+1)'(spd);
        inc      = cur + step;
        target   = !req ? cur
                 : dir_nx == DIR_POS ? (inc > LIM ? LIM : inc)
                 : (cur < step ? '0 : cur - step);
        hit      = req && (dir_nx == DIR_POS ? target == LIM : target == '0);
        speed_nx = hit ? '0 : spd;
        if (hit) begin
            state_nx = ST_IDLE;
            held_nx  = '0;
        end
    end

    // Axis state advances only on enabled motion ticks
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            dir   <= DIR_NEG;
            held  <= '0;
            speed <= '0;
            pos   <= POS_W'(INIT);
        end else if (step_en) begin
            state <= state_nx;
            dir   <= dir_nx;
            held  <= held_nx;
            speed <= speed_nx;
            pos   <= target[POS_W-1:0];
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: button-driven sprite mover with tick divider, speed ramp and screen clamping
module sprite_motion_ctrl
    import sprite_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int SPRITE_W    = SPRITE_W_DEF,
    parameter int SPRITE_H    = SPRITE_H_DEF,
    parameter int POS_W       = POS_W_DEF,
    parameter int TICK_DIV    = 131072,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_TICKS = 8,
    parameter int INIT_X      = INIT_X_DEF,
    parameter int INIT_Y      = INIT_Y_DEF
) (
    input  logic             clk25,
    input  logic             rst_n,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             freeze,
    output logic [POS_W-1:0] sprite_x,
    output logic [POS_W-1:0] sprite_y,
    output logic [2:0]       speed_x,
    output logic [2:0]       speed_y,
    output logic [3:0]       at_edge,
    output logic             moving
);

    localparam int            LIMIT_X  = SCREEN_W - SPRITE_W;
    localparam int            LIMIT_Y  = SCREEN_H - SPRITE_H;
    localparam int            DW       = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    generate
        if (INIT_X < 0 || INIT_X > LIMIT_X || INIT_Y < 0 || INIT_Y > LIMIT_Y) begin : g_bad_init
            $error("sprite_motion_ctrl: INIT_X/INIT_Y outside screen limits");
        end
        if (MAX_SPEED < 1 || MAX_SPEED > 7) begin : g_bad_speed
            $error("sprite_motion_ctrl: MAX_SPEED must be 1..7");
        end
        if (TICK_DIV < 2 || ACCEL_TICKS < 1 || LIMIT_X < 0 || LIMIT_Y < 0
            || LIMIT_X >= 2**POS_W || LIMIT_Y >= 2**POS_W) begin : g_bad_geom
            $error("sprite_motion_ctrl: bad TICK_DIV/ACCEL_TICKS or limits exceed POS_W");
        end
    endgenerate

    logic [1:0]    rst_sync;
    logic          rst_sync_n;
    logic [3:0]    btn_meta, btn_sync;
    logic [DW-1:0] div_cnt;
    logic          tick, step_en;

    assign rst_sync_n = rst_sync[1];
    assign tick       = div_cnt == DIV_LAST;
    assign step_en    = tick & ~freeze;

    // Assert reset immediately, release it two clk25 edges later
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    // Two-flop synchronizers for {left,right,up,down}
    always_ff @(posedge clk25 or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= {btn_left, btn_right, btn_up, btn_down};
            btn_sync <= btn_meta;
        end
    end

    // Free-running motion tick divider, unaffected by freeze
    always_ff @(posedge clk25 or negedge rst_sync_n) begin
        if (!rst_sync_n) div_cnt <= '0;
        else             div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    sprite_axis_motion #(
        .POS_W(POS_W), .LIMIT(LIMIT_X), .INIT(INIT_X),
        .MAX_SPEED(MAX_SPEED), .ACCEL_TICKS(ACCEL_TICKS)
    ) u_axis_x (
        .clk25(clk25), .rst_n(rst_sync_n), .step_en(step_en),
        .req_neg(btn_sync[3]), .req_pos(btn_sync[2]),
        .pos(sprite_x), .speed(speed_x)
    );

    sprite_axis_motion #(
        .POS_W(POS_W), .LIMIT(LIMIT_Y), .INIT(INIT_Y),
        .MAX_SPEED(MAX_SPEED), .ACCEL_TICKS(ACCEL_TICKS)
    ) u_axis_y (
        .clk25(clk25), .rst_n(rst_sync_n), .step_en(step_en),
        .req_neg(btn_sync[1]), .req_pos(btn_sync[0]),
        .pos(sprite_y), .speed(speed_y)
    );

    assign at_edge = {sprite_x == '0, sprite_x == POS_W'(LIMIT_X),
                      sprite_y == '0, sprite_y == POS_W'(LIMIT_Y)};
    assign moving  = |{speed_x, speed_y};

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed and random stimulus checked against a behavioural motion model
module tb_sprite_motion_ctrl;

    localparam int TD   = 4;
    localparam int ACC  = 2;
    localparam int MAXS = 4;
    localparam int LIMX = 640 - 32;
    localparam int LIMY = 480 - 32;

    logic       clk25, rst_n;
    logic       btn_left, btn_right, btn_up, btn_down, freeze;
    logic [9:0] sprite_x, sprite_y;
    logic [2:0] speed_x, speed_y;
    logic [3:0] at_edge;
    logic       moving;

    int checks   = 0;
    int failures = 0;
    int tick_cnt = 0;

    int   mpos[2], mspd[2], mheld[2], mdir[2];
    int   lim[2] = '{LIMX, LIMY};
    int   dcnt;
    bit   rs0, rs1;
    logic [3:0] b1, b2;

    sprite_motion_ctrl #(.TICK_DIV(TD), .ACCEL_TICKS(ACC), .MAX_SPEED(MAXS)) dut (
        .clk25(clk25), .rst_n(rst_n),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .freeze(freeze),
        .sprite_x(sprite_x), .sprite_y(sprite_y),
        .speed_x(speed_x), .speed_y(speed_y),
        .at_edge(at_edge), .moving(moving)
    );

    initial begin
        clk25 = 0;
        forever #5 clk25 = ~clk25;
    end

    task automatic check(input string name, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mpos  = '{304, 448};
        mspd  = '{0, 0};
        mheld = '{0, 0};
        mdir  = '{0, 0};
        dcnt  = 0;
        b1    = '0;
        b2    = '0;
    endtask

    // One axis for one enabled tick; req is -1 (toward 0), 0 (none), +1 (toward limit)
    task automatic axis_step(input int a, input int req);
        if (req == 0) begin
            mspd[a]  = 0;
            mheld[a] = 0;
            return;
        end
        if (mspd[a] == 0 || req != mdir[a]) begin
            mdir[a]  = req;
            mspd[a]  = 1;
            mheld[a] = 0;
        end else if (mspd[a] < MAXS) begin
            mheld[a]++;
            if (mheld[a] == ACC) begin
                mheld[a] = 0;
                mspd[a]++;
            end
        end
        mpos[a] += mdir[a] * mspd[a];
        if (mpos[a] < 0) mpos[a] = 0;
        if (mpos[a] > lim[a]) mpos[a] = lim[a];
        if ((mdir[a] < 0 && mpos[a] == 0) || (mdir[a] > 0 && mpos[a] == lim[a])) begin
            mspd[a]  = 0;
            mheld[a] = 0;
        end
    endtask

    task automatic model_step();
        bit         tick;
        logic [3:0] rq;
        if (!rst_n) begin
            model_reset();
            rs0 = 0;
            rs1 = 0;
            return;
        end
        if (!rs1) begin
            rs1 = rs0;
            rs0 = 1;
            model_reset();
            return;
        end
        tick = (dcnt == TD - 1);
        dcnt = (dcnt + 1) % TD;
        rq   = b2;
        b2   = b1;
        b1   = {btn_left, btn_right, btn_up, btn_down};
        if (tick) tick_cnt++;
        if (tick && !freeze) begin
            axis_step(0, int'(rq[2]) - int'(rq[3]));
            axis_step(1, int'(rq[0]) - int'(rq[1]));
        end
    endtask

    // Every cycle: advance the model past the edge just taken and compare all outputs
    always begin
        @(posedge clk25);
        #2;
        model_step();
        check("m_sprite_x", sprite_x, mpos[0]);
        check("m_sprite_y", sprite_y, mpos[1]);
        check("m_speed_x", speed_x, mspd[0]);
        check("m_speed_y", speed_y, mspd[1]);
        check("m_at_edge", at_edge, int'({mpos[0] == 0, mpos[0] == LIMX, mpos[1] == 0, mpos[1] == LIMY}));
        check("m_moving", moving, int'(mspd[0] != 0 || mspd[1] != 0));
    end

    task automatic wait_ticks(input int n);
        int t0 = tick_cnt;
        for (int k = 0; k < 20 * n && tick_cnt < t0 + n; k++) @(negedge clk25);
        check("tick_timeout", tick_cnt - t0 >= n, 1);
    endtask

    initial begin
        int ramp[8] = '{305, 306, 308, 310, 313, 316, 320, 324};
        rst_n = 1;
        {btn_left, btn_right, btn_up, btn_down, freeze} = '0;
        #1 rst_n = 0;
        repeat (3) @(negedge clk25);
        rst_n = 1;
        repeat (40) @(negedge clk25);
        check("rst_x", sprite_x, 304);
        check("rst_y", sprite_y, 448);
        check("rst_moving", moving, 0);
        check("rst_edge", at_edge, 4'b0001);

        wait_ticks(1);
        btn_right = 1;
        for (int i = 0; i < 8; i++) begin
            wait_ticks(1);
            check("ramp_x", sprite_x, ramp[i]);
        end
        check("cruise_speed", speed_x, 4);

        btn_right = 0;
        btn_left  = 1;
        wait_ticks(1);
        check("reverse_x", sprite_x, 323);
        check("reverse_speed", speed_x, 1);

        for (int i = 0; i < 150 && sprite_x != 0; i++) wait_ticks(1);
        check("left_wall_x", sprite_x, 0);
        check("left_wall_speed", speed_x, 0);

        btn_left  = 0;
        btn_right = 1;
        wait_ticks(2);
        check("nudge_x", sprite_x, 2);
        btn_right = 0;
        wait_ticks(1);
        check("release_x", sprite_x, 2);
        check("release_speed", speed_x, 0);
        btn_left = 1;
        wait_ticks(1);
        check("clamp1_x", sprite_x, 1);
        wait_ticks(1);
        check("clamp0_x", sprite_x, 0);
        check("clamp0_edge", at_edge[3], 1);
        check("clamp0_speed", speed_x, 0);
        btn_left = 0;

        btn_up = 1;
        wait_ticks(3);
        check("up_y", sprite_y, 444);
        btn_down = 1;
        wait_ticks(5);
        check("both_y", sprite_y, 444);
        check("both_speed", speed_y, 0);
        check("both_moving", moving, 0);
        {btn_up, btn_down} = '0;

        btn_right = 1;
        wait_ticks(10);
        check("cruise2_x", sprite_x, 28);
        check("cruise2_speed", speed_x, 4);
        rst_n = 0;
        #1;
        check("async_rst_x", sprite_x, 304);
        check("async_rst_y", sprite_y, 448);
        check("async_rst_sx", speed_x, 0);
        check("async_rst_sy", speed_y, 0);
        @(negedge clk25);
        rst_n = 1;
        @(negedge clk25);
        check("post_rst_x", sprite_x, 304);
        wait_ticks(1);
        check("fresh_tick_x", sprite_x, 305);
        btn_right = 0;

        for (int s = 0; s < 250; s++) begin
            {btn_left, btn_right, btn_up, btn_down} = 4'($urandom);
            freeze = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 59) == 0) rst_n = 0;
            repeat ($urandom_range(1, 40)) @(negedge clk25);
            rst_n = 1;
        end
        repeat (4) @(negedge clk25);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
